sdpram_fifo_ctrl: RTL and testbench

- Single-clock FIFO controller that drives one 2048x8 simple dual-port block RAM instance as a circular buffer.
- The RAM has one write port, one read port, no output register, and a 1-cycle read latency.
- The block presents valid/ready streaming interfaces on both sides. It hides the RAM read latency with a 2-entry prefetch queue, so a continuous stream flows at full throughput.
- It sits between the HDMI pixel/line producers and consumers on the board, as the sequencer for the shared line-buffer RAM.

---
 rtl/sdpram_fifo_ctrl.sv | 154 +++++++++++++++
 tb/tb_sdpram_fifo_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdpram_fifo_ctrl.sv
// sdpram_fifo_ctrl: single-clock FIFO sequencer around one simple dual-port
// block RAM (1-cycle read latency, no output register). A 2-entry prefetch
// queue in front of the read port hides that latency, so a stream can move
// one word per cycle in each direction.
module sdpram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = 2040,
    parameter int AE_LEVEL   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    // ram_cnt is one bit wider than the address so "completely full" is representable
    localparam logic [ADDR_WIDTH:0]   RAM_CAP = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH+1:0] AF_THR  = AF_LEVEL[ADDR_WIDTH+1:0];
    localparam logic [ADDR_WIDTH+1:0] AE_THR  = AE_LEVEL[ADDR_WIDTH+1:0];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   ram_cnt;
    logic                  inflight;
    logic [1:0]            q_occ;
    logic [DATA_WIDTH-1:0] q0;
    logic [DATA_WIDTH-1:0] q1;
    logic [ADDR_WIDTH+1:0] level_reg;
    logic                  af_reg;
    logic                  ae_reg;

    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            q_demand;
    logic [1:0]            q_after_pop;
    logic [ADDR_WIDTH:0]   ram_cnt_next;
    logic                  inflight_next;
    logic [1:0]            q_occ_next;
    logic [ADDR_WIDTH+1:0] level_next;
    logic [DATA_WIDTH-1:0] q0_next;
    logic [DATA_WIDTH-1:0] q1_next;

    // Accept only on the registered RAM count, so a same-cycle issue never
    // lets a word in early; reset and flush both block the write side.
    assign s_ready     = !rst && !flush && (ram_cnt < RAM_CAP);
    assign push        = s_valid && s_ready;
    assign m_valid     = (q_occ != 2'd0);
    assign m_data      = q0;
    assign pop         = m_valid && m_ready;

    // Queue slots already spoken for after this cycle's pop; a new read may
    // only start if a slot will still be free when its data lands.
    assign q_demand    = {1'b0, q_occ} + {2'b00, inflight} - {2'b00, pop};
    assign issue       = (ram_cnt != '0) && (q_demand < 3'd2) && !flush;
    assign q_after_pop = q_occ - {1'b0, pop};

    assign ram_wr_en   = push;
    assign ram_wr_data = s_data;
    assign ram_wr_addr = wr_ptr;
    assign ram_rd_addr = rd_ptr;

    assign level        = level_reg;
    assign almost_full  = af_reg;
    assign almost_empty = ae_reg;

    // Next-state occupancy, fill level and queue contents
    always_comb begin
        ram_cnt_next  = ram_cnt + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, issue};
        inflight_next = issue;
        q_occ_next    = q_after_pop + {1'b0, inflight};
        q0_next       = q0;
        q1_next       = q1;
        if (pop) begin
            q0_next = q1;
        end
        // Captured word goes behind whatever survives the pop
        if (inflight) begin
            if (q_after_pop == 2'd0) begin
                q0_next = ram_rd_data;
            end else begin
                q1_next = ram_rd_data;
            end
        end
        if (flush) begin
            ram_cnt_next  = '0;
            inflight_next = 1'b0;
            q_occ_next    = 2'd0;
        end
        level_next = {1'b0, ram_cnt_next} + {{(ADDR_WIDTH+1){1'b0}}, inflight_next}
                   + {{ADDR_WIDTH{1'b0}}, q_occ_next};
    end

    // Pointers, RAM word count and the one-cycle read-in-flight marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (issue) rd_ptr <= rd_ptr + 1'b1;
            end
            ram_cnt  <= ram_cnt_next;
            inflight <= inflight_next;
        end
    end

    // Prefetch queue: q0 is the head presented on m_data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_occ <= 2'd0;
            q0    <= '0;
            q1    <= '0;
        end else begin
            q_occ <= q_occ_next;
            q0    <= q0_next;
            q1    <= q1_next;
        end
    end

    // Registered fill level and watermark flags, taken from next-state level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_reg <= '0;
            af_reg    <= 1'b0;
            ae_reg    <= 1'b1;
        end else begin
            level_reg <= level_next;
            af_reg    <= (level_next >= AF_THR);
            ae_reg    <= (level_next <= AE_THR);
        end
    end

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// Directed testbench for sdpram_fifo_ctrl with a behavioural 2048x8 RAM.
module tb_sdpram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [12:0] level;
    logic        almost_full;
    logic        almost_empty;
    logic [7:0]  ram_wr_data;
    logic [10:0] ram_wr_addr;
    logic        ram_wr_en;
    logic [10:0] ram_rd_addr;
    logic [7:0]  ram_rd_data;

    logic [7:0]  mem [0:2047];

    int checks = 0;
    int passed = 0;

    sdpram_fifo_ctrl #(
        .ADDR_WIDTH(11), .DATA_WIDTH(8), .AF_LEVEL(2040), .AE_LEVEL(8)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
        .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    always #5 clk = ~clk;

    // Simple dual-port RAM, unregistered output, 1-cycle read latency
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Move to 1 time unit after the next rising edge (input-drive point)
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 8'h00;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] pat(int i);
        logic [31:0] u;
        u = i;
        return u[7:0] ^ {5'b00000, u[10:8]};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1; s_valid = 1'b1; s_data = 8'h11; m_ready = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b want 0", s_ready); else passed++;
        checks++; if (ram_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", ram_wr_en); else passed++;
        cyc();
        cyc();
        checks++; if ({m_valid, level, almost_full, almost_empty} !== {1'b0, 13'd0, 1'b0, 1'b1})
            $display("FAIL reset_state: m_valid=%b level=%0d af=%b ae=%b want 0/0/0/1", m_valid, level, almost_full, almost_empty);
        else passed++;
        s_valid = 1'b0; rst = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b1) $display("FAIL reset_release_s_ready: got %b want 1", s_ready); else passed++;
        checks++; if ({m_data, ram_wr_addr, ram_rd_addr} !== {8'h00, 11'd0, 11'd0})
            $display("FAIL reset_regs: m_data=%h wr_addr=%0d rd_addr=%0d want 0", m_data, ram_wr_addr, ram_rd_addr);
        else passed++;
        cyc();
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        m_ready = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
        #1;
        checks++; if ({ram_wr_en, ram_wr_addr, ram_wr_data} !== {1'b1, 11'd0, 8'hA5})
            $display("FAIL single_write: en=%b addr=%0d data=%h want 1/0/a5", ram_wr_en, ram_wr_addr, ram_wr_data);
        else passed++;
        cyc();
        s_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++; if (m_valid !== (k == 3)) $display("FAIL single_m_valid_c%0d: got %b want %b", k, m_valid, (k == 3)); else passed++;
            checks++; if (level !== ((k <= 3) ? 13'd1 : 13'd0)) $display("FAIL single_level_c%0d: got %0d want %0d", k, level, (k <= 3) ? 1 : 0); else passed++;
            if (k == 3) begin
                checks++; if (m_data !== 8'hA5) $display("FAIL single_m_data: got %h want a5", m_data); else passed++;
            end
            cyc();
        end
        $display("test_single done");
    endtask

    task automatic test_fill();
        int acc;
        int stall;
        int good;
        logic bad_v;
        logic [7:0] bad_d;
        do_reset();
        m_ready = 1'b0; acc = 0; stall = 0;
        for (int c = 0; c < 2200 && stall < 4; c++) begin
            s_valid = 1'b1; s_data = acc[7:0];
            #1;
            if (s_ready) acc++; else stall++;
            cyc();
        end
        checks++; if (acc !== 2050) $display("FAIL fill_accepted: got %0d want 2050", acc); else passed++;
        s_valid = 1'b0;
        cyc();
        cyc();
        #1;
        checks++; if (level !== 13'd2050) $display("FAIL fill_level: got %0d want 2050", level); else passed++;
        checks++; if ({almost_full, almost_empty, s_ready} !== 3'b100)
            $display("FAIL fill_flags: af=%b ae=%b s_ready=%b want 1/0/0", almost_full, almost_empty, s_ready);
        else passed++;
        cyc();
        m_ready = 1'b1; good = 0; bad_v = 1'b0; bad_d = 8'h00;
        for (int k = 0; k < 2050; k++) begin
            #1;
            if (m_valid !== 1'b1 || m_data !== good[7:0]) begin
                bad_v = m_valid; bad_d = m_data;
                break;
            end
            good++;
            cyc();
        end
        checks++; if (good !== 2050)
            $display("FAIL fill_drain: %0d gap-free in-order words, want 2050 (then m_valid=%b m_data=%h want 1/%h)", good, bad_v, bad_d, good[7:0]);
        else passed++;
        #1;
        checks++; if ({m_valid, level, almost_empty} !== {1'b0, 13'd0, 1'b1})
            $display("FAIL fill_empty: m_valid=%b level=%0d ae=%b want 0/0/1", m_valid, level, almost_empty);
        else passed++;
        m_ready = 1'b0;
        cyc();
        $display("test_fill done: %0d words", good);
    endtask

    task automatic test_stream();
        int sent, rcv, first, gaps, lvl_bad, data_bad;
        logic wrap_wr, wrap_rd;
        logic [10:0] prev_wr, prev_rd;
        do_reset();
        sent = 0; rcv = 0; first = -1; gaps = 0; lvl_bad = 0; data_bad = 0;
        wrap_wr = 1'b0; wrap_rd = 1'b0; prev_wr = 11'd0; prev_rd = 11'd0;
        m_ready = 1'b1;
        for (int c = 0; c < 5100 && rcv < 5000; c++) begin
            s_valid = (sent < 5000); s_data = pat(sent);
            #1;
            if (level > 13'd3) lvl_bad++;
            if (m_valid) begin
                if (first < 0) first = c;
                if (m_data !== pat(rcv)) data_bad++;
                rcv++;
            end else if (first >= 0) begin
                gaps++;
            end
            if (s_valid && s_ready) begin
                if (sent > 0 && prev_wr == 11'd2047 && ram_wr_addr == 11'd0) wrap_wr = 1'b1;
                prev_wr = ram_wr_addr;
                sent++;
            end
            if (prev_rd == 11'd2047 && ram_rd_addr == 11'd0) wrap_rd = 1'b1;
            prev_rd = ram_rd_addr;
            cyc();
        end
        s_valid = 1'b0; m_ready = 1'b0;
        checks++; if (first !== 3) $display("FAIL stream_latency: first m_valid at cycle %0d want 3", first); else passed++;
        checks++; if (rcv !== 5000) $display("FAIL stream_count: got %0d want 5000", rcv); else passed++;
        checks++; if (gaps !== 0) $display("FAIL stream_gaps: got %0d want 0", gaps); else passed++;
        checks++; if (data_bad !== 0) $display("FAIL stream_data: %0d bad words want 0", data_bad); else passed++;
        checks++; if (lvl_bad !== 0) $display("FAIL stream_level: %0d cycles above 3 want 0", lvl_bad); else passed++;
        checks++; if ({wrap_wr, wrap_rd} !== 2'b11) $display("FAIL stream_wrap: wr=%b rd=%b want 1/1", wrap_wr, wrap_rd); else passed++;
        cyc();
        $display("test_stream done: %0d words", rcv);
    endtask

    task automatic test_backpressure();
        logic [7:0] sb [$];
        logic [7:0] exp_d;
        int sent, rcv, data_bad, lvl_bad, bad_lvl, bad_exp;
        do_reset();
        sent = 0; rcv = 0; data_bad = 0; lvl_bad = 0; bad_lvl = 0; bad_exp = 0;
        for (int c = 0; c < 60000 && rcv < 10000; c++) begin
            s_valid = (sent < 10000) && ($urandom_range(0, 1) == 1);
            s_data  = 8'($urandom_range(0, 255));
            m_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (int'(level) != sb.size() || almost_empty !== (sb.size() <= 8) || almost_full !== (sb.size() >= 2040)) begin
                if (lvl_bad == 0) begin bad_lvl = int'(level); bad_exp = sb.size(); end
                lvl_bad++;
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    data_bad++;
                end else begin
                    exp_d = sb.pop_front();
                    if (m_data !== exp_d) data_bad++;
                end
                rcv++;
            end
            if (s_valid && s_ready) begin
                sb.push_back(s_data);
                sent++;
            end
            cyc();
        end
        s_valid = 1'b0; m_ready = 1'b0;
        checks++; if (rcv !== 10000) $display("FAIL bp_count: got %0d want 10000", rcv); else passed++;
        checks++; if (data_bad !== 0) $display("FAIL bp_data: %0d bad words want 0", data_bad); else passed++;
        checks++; if (lvl_bad !== 0) $display("FAIL bp_level: %0d bad cycles, first level=%0d want %0d", lvl_bad, bad_lvl, bad_exp); else passed++;
        cyc();
        $display("test_backpressure done: %0d words", rcv);
    endtask

    task automatic test_flush();
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 100; i++) begin
            s_valid = 1'b1; s_data = i[7:0];
            cyc();
        end
        s_valid = 1'b0;
        cyc();
        cyc();
        #1;
        checks++; if ({level, m_valid, m_data} !== {13'd100, 1'b1, 8'h00})
            $display("FAIL flush_pre: level=%0d m_valid=%b m_data=%h want 100/1/00", level, m_valid, m_data);
        else passed++;
        cyc();
        flush = 1'b1; s_valid = 1'b1; s_data = 8'hEE; m_ready = 1'b1;
        #1;
        checks++; if ({s_ready, ram_wr_en} !== 2'b00) $display("FAIL flush_block: s_ready=%b wr_en=%b want 0/0", s_ready, ram_wr_en); else passed++;
        cyc();
        flush = 1'b0; s_valid = 1'b1; s_data = 8'h3C;
        #1;
        checks++; if ({level, m_valid} !== {13'd0, 1'b0}) $display("FAIL flush_after: level=%0d m_valid=%b want 0/0", level, m_valid); else passed++;
        checks++; if ({ram_wr_en, ram_wr_addr, ram_rd_addr} !== {1'b1, 11'd0, 11'd0})
            $display("FAIL flush_ptrs: wr_en=%b wr_addr=%0d rd_addr=%0d want 1/0/0", ram_wr_en, ram_wr_addr, ram_rd_addr);
        else passed++;
        cyc();
        s_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            checks++; if (m_valid !== (k == 3)) $display("FAIL flush_3c_valid_c%0d: got %b want %b", k, m_valid, (k == 3)); else passed++;
            if (k == 3) begin
                checks++; if (m_data !== 8'h3C) $display("FAIL flush_3c_data: got %h want 3c", m_data); else passed++;
            end
            cyc();
        end
        m_ready = 1'b0;
        $display("test_flush done");
    endtask

    task automatic test_async_reset();
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 8'h50 + i[7:0];
            cyc();
        end
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        #2;
        checks++; if ({m_valid, level} !== {1'b1, 13'd4}) $display("FAIL arst_pre: m_valid=%b level=%0d want 1/4", m_valid, level); else passed++;
        s_valid = 1'b1; rst = 1'b1;
        #1;
        checks++; if ({m_valid, level, ram_wr_en, s_ready, almost_empty} !== {1'b0, 13'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL arst_now: m_valid=%b level=%0d wr_en=%b s_ready=%b ae=%b want 0/0/0/0/1", m_valid, level, ram_wr_en, s_ready, almost_empty);
        else passed++;
        cyc();
        cyc();
        s_valid = 1'b0; rst = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b1) $display("FAIL arst_release: s_ready=%b want 1", s_ready); else passed++;
        m_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        #1;
        checks++; if ({m_valid, level} !== {1'b0, 13'd0}) $display("FAIL arst_dropped: m_valid=%b level=%0d want 0/0", m_valid, level); else passed++;
        m_ready = 1'b0;
        cyc();
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
